tri_pixel_buffer: RTL and testbench
===================================

TRI_PIXEL_BUFFER -- requirements
Module: tri_pixel_buffer

Interface
REQ-001 The block SHALL have clk, input, 1, rising-edge clock.
REQ-002 The block SHALL have reset, input, 1, asynchronous active-high reset.
REQ-003 The block SHALL have po, input, 1, pixel-valid strobe from the triangle rasterizer.
REQ-004 The block SHALL have xi / yi, input, 3 each, pixel column / row, qualified by po.
REQ-005 The block SHALL have src_busy, input, 1, rasterizer busy flag, used for end-of-frame detection.
REQ-006 The block SHALL have rd_ready, input, 1, downstream row-accept.
REQ-007 The block SHALL have row_valid, output, 1, row_data / row_idx are valid.
REQ-008 The block SHALL have row_data, output, 8, bit m = pixel (x=m, y=row_idx).
REQ-009 The block SHALL have row_idx, output, 3, row being presented.
REQ-010 The block SHALL have pix_count, output, 7, distinct pixels in the current frame (0..64).
REQ-011 The block SHALL have lost, output, 1, sticky flag: a pixel arrived outside COLLECT.
REQ-012 The block SHALL have frame_done, output, 1, one-cycle pulse after row 7 is accepted.

Function
REQ-013 The block SHALL hold a 64-bit bitmap and a registered copy of src_busy (busy_d).
REQ-014 The FSM SHALL have the states COLLECT, SEAL, DRAIN and CLEAR.
REQ-015 In COLLECT, po=1 SHALL set bitmap[yi*8+xi] on the next edge.
REQ-016 In COLLECT, pix_count SHALL increment only if that bit was previously 0.
REQ-017 An end-of-frame event SHALL be busy_d=1 and src_busy=0 while in COLLECT.
REQ-018 On an end-of-frame event the FSM SHALL go COLLECT->SEAL.
REQ-019 A po arriving in the same cycle as the end-of-frame event SHALL still be captured.
REQ-020 SEAL SHALL last exactly 1 cycle, set row_idx=0, and then go to DRAIN.
REQ-021 In DRAIN, row_valid SHALL be 1 and row_data SHALL equal bitmap row row_idx.
REQ-022 In DRAIN, row_data and row_idx SHALL be held stable until rd_ready=1.
REQ-023 A transfer SHALL occur on a cycle with row_valid=1 and rd_ready=1.
REQ-024 On a transfer, row_idx SHALL increment.
REQ-025 A transfer with row_idx=7 SHALL go to CLEAR and pulse frame_done in that CLEAR cycle.
REQ-026 Back-to-back transfers SHALL be supported: 8 rows in 8 cycles when rd_ready is held at 1.
REQ-027 CLEAR SHALL last 1 cycle, zero the bitmap and pix_count, and then go to COLLECT.
REQ-028 In SEAL, DRAIN and CLEAR, a po=1 SHALL be dropped and SHALL set lost.
REQ-029 lost SHALL be cleared only by reset.
REQ-030 pix_count SHALL hold its final value through SEAL and DRAIN.
REQ-031 pix_count SHALL saturate at 64, which is reachable only by a full grid.
REQ-032 row_valid SHALL be 0 outside DRAIN.
REQ-033 row_data SHALL be 0 outside DRAIN.
REQ-034 A src_busy falling edge outside COLLECT SHALL be ignored.
REQ-035 An empty frame (falling edge with no pixels) SHALL still drain 8 rows of 0 with pix_count=0.

Reset
REQ-036 Reset asserted SHALL immediately put the FSM in COLLECT, including mid-DRAIN.
REQ-037 Reset asserted SHALL immediately zero the bitmap, busy_d, pix_count and row_idx.
REQ-038 Reset asserted SHALL immediately set row_valid, row_data, lost and frame_done to 0.
REQ-039 The first rising clk edge after reset release SHALL accept pixels.

Verification
REQ-040 The bench SHALL cover a single frame: src_busy 1, po at (0,0),(3,2),(7,7), src_busy 0 -> rows: row0=8'h01, row2=8'h08, row7=8'h80, others 0; pix_count=3; frame_done pulses once.
REQ-041 The bench SHALL cover duplicate pixels: (5,5) sent three times -> pix_count=1, row5=8'h20.
REQ-042 The bench SHALL cover backpressure: rd_ready toggling 1,0,0,1 during DRAIN -> row_idx/row_data held across the stall, no row skipped or repeated, 8 transfers total.
REQ-043 The bench SHALL cover a pixel during drain: po at (1,1) while in DRAIN -> lost=1, next frame bitmap excludes (1,1), pix_count restarts at 0 after CLEAR.
REQ-044 The bench SHALL cover simultaneous events: po at (2,4) on the same cycle src_busy falls -> row4=8'h04 present in the drained frame.
REQ-045 The bench SHALL cover reset mid-DRAIN: reset at row_idx=3 -> row_valid=0 asynchronously; next frame starts from an empty bitmap, lost=0.

Source files
------------

// File: rtl/tri_pixel_buffer.sv
// Collects rasterizer pixels into an 8x8 bitmap, then drains it row by row
// to a ready/valid consumer once the rasterizer drops its busy flag.
module tri_pixel_buffer (
   input  logic       clk,
   input  logic       reset,
   input  logic       po,
   input  logic [2:0] xi,
   input  logic [2:0] yi,
   input  logic       src_busy,
   input  logic       rd_ready,
   output logic       row_valid,
   output logic [7:0] row_data,
   output logic [2:0] row_idx,
   output logic [6:0] pix_count,
   output logic       lost,
   output logic       frame_done
);

   typedef enum logic [1:0] {COLLECT, SEAL, DRAIN, CLEAR} state_t;

   state_t      state, state_nx;
   logic [63:0] bitmap;
   logic        busy_d;
   logic        eof;
   logic        capture;
   logic        xfer;
   logic [5:0]  pix_addr;

   assign pix_addr = {yi, xi};
   assign capture  = po && (state == COLLECT);
   assign eof      = (state == COLLECT) && busy_d && !src_busy;
   assign xfer     = (state == DRAIN) && rd_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= COLLECT;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         COLLECT: if (eof) state_nx = SEAL;
         SEAL:    state_nx = DRAIN;
         DRAIN:   if (xfer && (row_idx == 3'd7)) state_nx = CLEAR;
         CLEAR:   state_nx = COLLECT;
         default: state_nx = COLLECT;
      endcase
   end

   // Count only first hits so duplicates from overlapping edges don't inflate the total.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bitmap    <= 64'd0;
         pix_count <= 7'd0;
      end else if (state == CLEAR) begin
         bitmap    <= 64'd0;
         pix_count <= 7'd0;
      end else if (capture) begin
         bitmap[pix_addr] <= 1'b1;
         if (!bitmap[pix_addr] && (pix_count != 7'd64))
            pix_count <= pix_count + 7'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_d  <= 1'b0;
         row_idx <= 3'd0;
         lost    <= 1'b0;
      end else begin
         busy_d <= src_busy;
         if (state == SEAL)
            row_idx <= 3'd0;
         else if (xfer)
            row_idx <= row_idx + 3'd1;
         if (po && (state != COLLECT))
            lost <= 1'b1;
      end
   end

   assign row_valid  = (state == DRAIN);
   assign row_data   = (state == DRAIN) ? bitmap[{row_idx, 3'b000} +: 8] : 8'd0;
   assign frame_done = (state == CLEAR);

endmodule

// File: tb/tb_tri_pixel_buffer.sv
// Directed bench for tri_pixel_buffer: a bitmap model fills a row scoreboard
// at end of frame, and each accepted row is popped and compared.
module tb_tri_pixel_buffer;

   logic       clk = 1'b0;
   logic       reset;
   logic       po;
   logic [2:0] xi;
   logic [2:0] yi;
   logic       src_busy;
   logic       rd_ready;
   logic       row_valid;
   logic [7:0] row_data;
   logic [2:0] row_idx;
   logic [6:0] pix_count;
   logic       lost;
   logic       frame_done;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] mbm = 64'd0;
   int          mcount = 0;
   logic [10:0] expq[$];
   logic [10:0] e;

   tri_pixel_buffer dut (
      .clk        (clk),
      .reset      (reset),
      .po         (po),
      .xi         (xi),
      .yi         (yi),
      .src_busy   (src_busy),
      .rd_ready   (rd_ready),
      .row_valid  (row_valid),
      .row_data   (row_data),
      .row_idx    (row_idx),
      .pix_count  (pix_count),
      .lost       (lost),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input int x, input int y);
      po = 1'b1;
      xi = x[2:0];
      yi = y[2:0];
      if (!mbm[y*8+x]) begin
         mbm[y*8+x] = 1'b1;
         mcount++;
      end
      tick();
      po = 1'b0;
   endtask

   // Drop src_busy (optionally with a pixel in the same cycle), queue the expected rows,
   // and step through SEAL into the first DRAIN cycle.
   task automatic end_frame(input bit wp, input int x, input int y);
      src_busy = 1'b0;
      if (wp) begin
         po = 1'b1;
         xi = x[2:0];
         yi = y[2:0];
         if (!mbm[y*8+x]) begin
            mbm[y*8+x] = 1'b1;
            mcount++;
         end
      end
      for (int r = 0; r < 8; r++) expq.push_back({r[2:0], mbm[r*8 +: 8]});
      tick();
      po = 1'b0;
      chk("seal_valid", row_valid, 0);
      chk("seal_data", row_data, 0);
      chk("seal_count", pix_count, mcount);
      tick();
      chk("drain_idx0", row_idx, 0);
   endtask

   // mode 0: rd_ready held high; 1: rd_ready 1,0,0,1 pattern with src_busy wiggling;
   // 2: rd_ready high with a stray pixel at (1,1).
   task automatic drain(input int mode);
      int          cyc;
      int          nx;
      bit          pstall;
      logic [2:0]  pidx;
      logic [7:0]  pdata;
      logic [10:0] d;
      cyc = 0; nx = 0; pstall = 1'b0; pidx = 3'd0; pdata = 8'd0;
      while (nx < 8 && cyc < 60) begin
         rd_ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         if (mode == 1) src_busy = cyc[0];
         po = (mode == 2) && (cyc == 2);
         xi = 3'd1;
         yi = 3'd1;
         chk("drain_valid", row_valid, 1);
         chk("drain_done_low", frame_done, 0);
         chk("drain_count", pix_count, mcount);
         if (pstall) begin
            chk("hold_idx", row_idx, pidx);
            chk("hold_data", row_data, pdata);
         end
         if (rd_ready) begin
            d = (expq.size() != 0) ? expq.pop_front() : 11'h7ff;
            chk("row_idx", row_idx, d[10:8]);
            chk("row_data", row_data, d[7:0]);
            nx++;
            pstall = 1'b0;
         end else begin
            pstall = 1'b1;
            pidx   = row_idx;
            pdata  = row_data;
         end
         tick();
         cyc++;
      end
      rd_ready = 1'b0;
      po       = 1'b0;
      src_busy = 1'b0;
      chk("xfer_count", nx, 8);
      if (mode == 0) chk("xfer_cycles", cyc, 8);
      chk("clear_done", frame_done, 1);
      chk("clear_valid", row_valid, 0);
      tick();
      chk("done_pulse", frame_done, 0);
      chk("count_zero", pix_count, 0);
      chk("post_valid", row_valid, 0);
      chk("post_data", row_data, 0);
      mbm    = 64'd0;
      mcount = 0;
   endtask

   initial begin
      reset = 1'b1; po = 1'b0; xi = 3'd0; yi = 3'd0;
      src_busy = 1'b0; rd_ready = 1'b0;
      #12;
      chk("rst_valid", row_valid, 0);
      chk("rst_data", row_data, 0);
      chk("rst_idx", row_idx, 0);
      chk("rst_count", pix_count, 0);
      chk("rst_lost", lost, 0);
      chk("rst_done", frame_done, 0);
      #1 reset = 1'b0;

      // single frame, first pixel on the first edge after reset release
      src_busy = 1'b1;
      pix(0, 0); pix(3, 2); pix(7, 7);
      chk("a_count", pix_count, 3);
      end_frame(1'b0, 0, 0);
      drain(0);
      chk("a_lost", lost, 0);

      // duplicates under backpressure
      src_busy = 1'b1;
      tick();
      pix(5, 5); pix(5, 5); pix(5, 5);
      chk("b_count", pix_count, 1);
      end_frame(1'b0, 0, 0);
      drain(1);

      // pixel coinciding with end-of-frame, stray pixel during drain
      src_busy = 1'b1;
      tick();
      pix(6, 0);
      end_frame(1'b1, 2, 4);
      drain(2);
      chk("c_lost", lost, 1);

      // reset in the middle of draining
      src_busy = 1'b1;
      tick();
      pix(0, 1); pix(6, 3);
      end_frame(1'b0, 0, 0);
      rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         e = expq.pop_front();
         chk("d_row_idx", row_idx, e[10:8]);
         chk("d_row_data", row_data, e[7:0]);
         tick();
      end
      chk("pre_rst_idx", row_idx, 3);
      chk("pre_rst_valid", row_valid, 1);
      rd_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", row_valid, 0);
      chk("mid_rst_data", row_data, 0);
      chk("mid_rst_idx", row_idx, 0);
      chk("mid_rst_count", pix_count, 0);
      chk("mid_rst_lost", lost, 0);
      chk("mid_rst_done", frame_done, 0);
      #1 reset = 1'b0;
      expq.delete();
      mbm = 64'd0;
      mcount = 0;

      // fresh frame after reset
      src_busy = 1'b1;
      pix(4, 6);
      end_frame(1'b0, 0, 0);
      drain(0);

      // empty frame
      src_busy = 1'b1;
      tick();
      tick();
      end_frame(1'b0, 0, 0);
      drain(0);
      chk("f_lost", lost, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
